// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, opcodes, FSM states, strobes.
// Pure declarations, no timing or backpressure of its own.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_B    = 4'b0001;
   localparam logic [3:0] STRB_H    = 4'b0011;
   localparam logic [3:0] STRB_W    = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   function automatic logic load_f3_legal(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a read word and sign- or zero-extends it.
// Purely combinational, zero latency; no backpressure.
// Illegal load_type values yield zero.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_load_type,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_data = 32'h0;
      case (i_load_type)
         F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         F3_LH:   o_data = {{16{w_half[15]}}, w_half};
         F3_LW:   o_data = i_rdata;
         F3_LBU:  o_data = {24'h0, w_byte};
         F3_LHU:  o_data = {16'h0, w_half};
         default: o_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding data-memory port with alignment, extension and legality checks.
// Latency accept->done: 2 cycles with zero-wait memory, 1 cycle on error; LSU_TIMEOUT_EN adds an ACCESS watchdog.
// Backpressure: busy stalls the pipeline from accept until done; req_valid outside IDLE is ignored.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  load_type,
   input  logic [2:0]  store_type,
   input  logic [31:0] base,
   input  logic [31:0] offset,
   input  logic [31:0] store_data,
   input  logic [3:0]  rd_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic [3:0]  rd_out,
   output logic        wb_en,
   output logic        misaligned,
   output logic        access_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   lsu_state_e  r_state;
   logic        r_done, r_wb_en, r_misal, r_fault, r_is_load;
   logic        r_mem_req, r_mem_we;
   logic [2:0]  r_type;
   logic [1:0]  r_addr_lo;
   logic [3:0]  r_rd, r_mem_wstrb;
   logic [31:0] r_load_data, r_mem_addr, r_mem_wdata;

   logic        w_accept, w_fault, w_misal;
   logic [2:0]  w_funct;
   logic [31:0] w_addr, w_wdata, w_load_ext;
   logic [3:0]  w_wstrb;

`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
`endif

   assign w_accept = (r_state == ST_IDLE) && req_valid && (is_load || is_store) && !rst;
   assign w_addr   = base + offset;
   assign w_funct  = is_load ? load_type : store_type;
   assign w_fault  = (is_load && is_store) ||
                     (is_load ? !load_f3_legal(load_type) : (store_type > F3_SW));

   // funct3[1:0] gives the access size for both loads and stores
   always_comb begin
      w_misal = 1'b0;
      w_wstrb = STRB_NONE;
      w_wdata = 32'h0;
      case (w_funct[1:0])
         2'b01:   w_misal = w_addr[0];
         2'b10:   w_misal = (w_addr[1:0] != 2'b00);
         default: w_misal = 1'b0;
      endcase
      case (store_type)
         F3_SB: begin
            w_wstrb = STRB_B << w_addr[1:0];
            w_wdata = {4{store_data[7:0]}};
         end
         F3_SH: begin
            w_wstrb = STRB_H << {w_addr[1], 1'b0};
            w_wdata = {2{store_data[15:0]}};
         end
         F3_SW: begin
            w_wstrb = STRB_W;
            w_wdata = store_data;
         end
         default: ;
      endcase
   end

   lsu_load_align u_align (
      .i_rdata     (mem_rdata),
      .i_addr_lo   (r_addr_lo),
      .i_load_type (r_type),
      .o_data      (w_load_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_done      <= 1'b0;
         r_wb_en     <= 1'b0;
         r_misal     <= 1'b0;
         r_fault     <= 1'b0;
         r_is_load   <= 1'b0;
         r_type      <= 3'b000;
         r_addr_lo   <= 2'b00;
         r_rd        <= 4'h0;
         r_load_data <= 32'h0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'h0;
         r_mem_wstrb <= STRB_NONE;
         r_mem_wdata <= 32'h0;
`ifdef LSU_TIMEOUT_EN
         r_cnt       <= '0;
`endif
      end else begin
         r_done  <= 1'b0;
         r_wb_en <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_accept) begin
               r_is_load   <= is_load;
               r_type      <= w_funct;
               r_addr_lo   <= w_addr[1:0];
               r_rd        <= rd_in;
               r_misal     <= w_misal;
               r_fault     <= w_fault;
               r_load_data <= 32'h0;
`ifdef LSU_TIMEOUT_EN
               r_cnt       <= '0;
`endif
               if (w_fault || w_misal) begin
                  r_state <= ST_RESP;
                  r_done  <= 1'b1;
               end else begin
                  r_state     <= ST_ACCESS;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= !is_load;
                  r_mem_addr  <= {w_addr[31:2], 2'b00};
                  r_mem_wstrb <= is_load ? STRB_NONE : w_wstrb;
                  r_mem_wdata <= is_load ? 32'h0 : w_wdata;
               end
            end
            ST_ACCESS: begin
               if (mem_ready) begin
                  r_mem_req <= 1'b0;
                  r_state   <= ST_RESP;
                  r_done    <= 1'b1;
                  if (r_is_load) begin
                     r_load_data <= w_load_ext;
                     r_wb_en     <= (r_rd != 4'h0);
                  end
               end
`ifdef LSU_TIMEOUT_EN
               else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  r_mem_req <= 1'b0;
                  r_fault   <= 1'b1;
                  r_state   <= ST_RESP;
                  r_done    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy         = (r_state != ST_IDLE) || w_accept;
   assign done         = r_done;
   assign wb_en        = r_wb_en;
   assign load_data    = r_load_data;
   assign rd_out       = r_rd;
   assign misaligned   = r_misal;
   assign access_fault = r_fault;
   assign mem_req      = r_mem_req;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_wstrb    = r_mem_wstrb;
   assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, error paths, wait states, reset abort, timeout.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst, req_valid, is_load, is_store, mem_ready;
   logic [2:0]  load_type, store_type;
   logic [31:0] base, offset, store_data, mem_rdata;
   logic [3:0]  rd_in;
   logic        busy, done, wb_en, misaligned, access_fault, mem_req, mem_we;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic [3:0]  rd_out, mem_wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
      .load_type(load_type), .store_type(store_type), .base(base), .offset(offset),
      .store_data(store_data), .rd_in(rd_in), .busy(busy), .done(done), .load_data(load_data),
      .rd_out(rd_out), .wb_en(wb_en), .misaligned(misaligned), .access_fault(access_fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] b, input logic [31:0] o,
                            input logic [31:0] sd, input logic [3:0] rd);
      req_valid = 1'b1; is_load = ld; is_store = st;
      load_type = f3; store_type = f3;
      base = b; offset = o; store_data = sd; rd_in = rd;
   endtask

   task automatic clear_req;
      req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; clear_req(); mem_ready = 1'b0; mem_rdata = 32'h0;
      load_type = 3'b0; store_type = 3'b0; base = 32'h0; offset = 32'h0;
      store_data = 32'h0; rd_in = 4'h0;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({busy, done, wb_en, misaligned, access_fault, mem_req, mem_we} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000000",
                  {busy, done, wb_en, misaligned, access_fault, mem_req, mem_we});
      end
      checks++;
      if ({load_data, mem_addr, mem_wdata, mem_wstrb, rd_out} !== 104'h0) begin
         errors++;
         $display("FAIL reset_buses: got %h/%h/%h/%h/%h want all zero",
                  load_data, mem_addr, mem_wdata, mem_wstrb, rd_out);
      end
   endtask

   task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] b,
                            input logic [31:0] o, input logic [31:0] rdata, input logic [3:0] rd,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data,
                            input logic exp_wb);
      drive_req(1'b1, 1'b0, f3, b, o, 32'h0, rd);
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_accept: got %b want 1", nm, busy); end
      tick();
      clear_req(); mem_ready = 1'b1; mem_rdata = rdata;
      checks++;
      if ({mem_req, mem_we, mem_wstrb, done} !== 7'b1000000 || mem_addr !== exp_addr) begin
         errors++;
         $display("FAIL %s_request: got req=%b we=%b strb=%b done=%b addr=%h want 1/0/0000/0/%h",
                  nm, mem_req, mem_we, mem_wstrb, done, mem_addr, exp_addr);
      end
      tick();
      mem_ready = 1'b0;
      checks++;
      if (done !== 1'b1 || load_data !== exp_data || wb_en !== exp_wb || rd_out !== rd ||
          misaligned !== 1'b0 || access_fault !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s_resp: got done=%b data=%h wb=%b rd=%h mis=%b flt=%b req=%b want 1/%h/%b/%h/0/0/0",
                  nm, done, load_data, wb_en, rd_out, misaligned, access_fault, mem_req,
                  exp_data, exp_wb, rd);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || load_data !== exp_data) begin
         errors++;
         $display("FAIL %s_after: got done=%b busy=%b data=%h want 0/0/%h",
                  nm, done, busy, load_data, exp_data);
      end
   endtask

   task automatic test_store(input string nm, input logic [2:0] f3, input logic [31:0] b,
                             input logic [31:0] o, input logic [31:0] sd,
                             input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata);
      drive_req(1'b0, 1'b1, f3, b, o, sd, 4'h9);
      tick();
      clear_req(); mem_ready = 1'b1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr ||
          mem_wstrb !== exp_strb || mem_wdata !== exp_wdata) begin
         errors++;
         $display("FAIL %s_request: got req=%b we=%b addr=%h strb=%b wdata=%h want 1/1/%h/%b/%h",
                  nm, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, exp_addr, exp_strb, exp_wdata);
      end
      tick();
      mem_ready = 1'b0;
      checks++;
      if (done !== 1'b1 || wb_en !== 1'b0 || load_data !== 32'h0 || access_fault !== 1'b0) begin
         errors++;
         $display("FAIL %s_resp: got done=%b wb=%b data=%h flt=%b want 1/0/00000000/0",
                  nm, done, wb_en, load_data, access_fault);
      end
      tick();
   endtask

   task automatic test_error(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] b, input logic [31:0] o,
                             input logic exp_mis, input logic exp_flt);
      drive_req(ld, st, f3, b, o, 32'hFFFF_FFFF, 4'h3);
      tick();
      clear_req(); mem_ready = 1'b0;
      checks++;
      if (done !== 1'b1 || mem_req !== 1'b0 || misaligned !== exp_mis ||
          access_fault !== exp_flt || wb_en !== 1'b0) begin
         errors++;
         $display("FAIL %s: got done=%b req=%b mis=%b flt=%b wb=%b want 1/0/%b/%b/0",
                  nm, done, mem_req, misaligned, access_fault, wb_en, exp_mis, exp_flt);
      end
      tick();
      checks++;
      if (done !== 1'b0 || mem_req !== 1'b0 || misaligned !== exp_mis) begin
         errors++;
         $display("FAIL %s_after: got done=%b req=%b mis=%b want 0/0/%b", nm, done, mem_req, misaligned, exp_mis);
      end
   endtask

   task automatic test_ignored;
      req_valid = 1'b1; is_load = 1'b0; is_store = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL ignored_busy: got %b want 0", busy); end
      tick();
      clear_req();
      checks++;
      if ({busy, mem_req, done} !== 3'b000) begin
         errors++;
         $display("FAIL ignored_state: got busy/req/done=%b want 000", {busy, mem_req, done});
      end
   endtask

   task automatic test_wait_states;
      drive_req(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 4'h7);
      tick();
      clear_req(); mem_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin clear_req(); mem_ready = 1'b1; mem_rdata = 32'h1122_3344; end
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h500 || mem_we !== 1'b0 ||
             mem_wstrb !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL wait_stable_%0d: got req=%b addr=%h we=%b strb=%b busy=%b done=%b want 1/500/0/0000/1/0",
                     i, mem_req, mem_addr, mem_we, mem_wstrb, busy, done);
         end
         if (i == 1) drive_req(1'b0, 1'b1, 3'b010, 32'h900, 32'h0, 32'h5555_5555, 4'h2);
         tick();
      end
      mem_ready = 1'b0;
      checks++;
      if (done !== 1'b1 || load_data !== 32'h1122_3344 || wb_en !== 1'b1 || rd_out !== 4'h7) begin
         errors++;
         $display("FAIL wait_resp: got done=%b data=%h wb=%b rd=%h want 1/11223344/1/7",
                  done, load_data, wb_en, rd_out);
      end
      tick();
      checks++;
      if ({mem_req, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL wait_second_ignored: got req/busy/done=%b want 000", {mem_req, busy, done});
      end
   endtask

   task automatic test_reset_mid_access;
      drive_req(1'b0, 1'b1, 3'b010, 32'hA00, 32'h0, 32'h1234_5678, 4'h1);
      tick();
      clear_req(); mem_ready = 1'b0;
      tick(); tick();
      checks++;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got req=%b want 1", mem_req); end
      rst = 1'b1;
      tick();
      checks++;
      if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_drop: got req=%b busy=%b done=%b want 0/0/0", mem_req, busy, done);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_nodone_%0d: got done=%b req=%b want 0/0", i, done, mem_req);
         end
      end
   endtask

   task automatic test_timeout;
      drive_req(1'b1, 1'b0, 3'b010, 32'hB00, 32'h0, 32'h0, 4'h3);
      tick();
      clear_req(); mem_ready = 1'b0;
`ifdef LSU_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem_req !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait_%0d: got req=%b done=%b want 1/0", i, mem_req, done);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || access_fault !== 1'b1 || wb_en !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL timeout_resp: got done=%b flt=%b wb=%b req=%b want 1/1/0/0",
                  done, access_fault, wb_en, mem_req);
      end
      tick();
`else
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (busy !== 1'b1 || mem_req !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout_hold: got busy=%b req=%b done=%b want 1/1/0", busy, mem_req, done);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
`endif
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_load("lb",   3'b000, 32'h100, 32'h3,         32'h80FF_1234, 4'h5, 32'h100, 32'hFFFF_FF80, 1'b1);
      test_load("lhu",  3'b101, 32'h200, 32'h2,         32'hBEEF_0000, 4'h6, 32'h200, 32'h0000_BEEF, 1'b1);
      test_load("lh",   3'b001, 32'h200, 32'h2,         32'hBEEF_0000, 4'h6, 32'h200, 32'hFFFF_BEEF, 1'b1);
      test_load("lbu",  3'b100, 32'h600, 32'h1,         32'hAA55_C3F0, 4'hA, 32'h600, 32'h0000_00C3, 1'b1);
      test_load("lb1",  3'b000, 32'h600, 32'h1,         32'hAA55_C3F0, 4'hA, 32'h600, 32'hFFFF_FFC3, 1'b1);
      test_load("lw_r0",3'b010, 32'h10,  32'hFFFF_FFF4, 32'hDEAD_BEEF, 4'h0, 32'h004, 32'hDEAD_BEEF, 1'b0);
      test_store("sh",  3'b001, 32'h300, 32'h2, 32'h1234_ABCD, 32'h300, 4'b1100, 32'hABCD_ABCD);
      test_store("sb",  3'b000, 32'h700, 32'h2, 32'h0000_00A5, 32'h700, 4'b0100, 32'hA5A5_A5A5);
      test_store("sw",  3'b010, 32'h800, 32'h4, 32'hCAFE_F00D, 32'h804, 4'b1111, 32'hCAFE_F00D);
      test_error("lw_misal",  1'b1, 1'b0, 3'b010, 32'h400, 32'h1, 1'b1, 1'b0);
      test_error("lh_misal",  1'b1, 1'b0, 3'b001, 32'h400, 32'h3, 1'b1, 1'b0);
      test_error("st_f3_011", 1'b0, 1'b1, 3'b011, 32'h400, 32'h0, 1'b0, 1'b1);
      test_error("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h400, 32'h0, 1'b0, 1'b1);
      test_error("ld_and_st", 1'b1, 1'b1, 3'b000, 32'h400, 32'h0, 1'b0, 1'b1);
      test_ignored();
      test_wait_states();
      test_reset_mid_access();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
